reg_rename_ckpt: RTL and testbench

- Architectural register file plus rename-status table for the out-of-order core.
- Sits between decoder/issue and ROB commit.
- Supplies NUM_RD operand lookups per cycle with same-cycle commit bypass.
- Adds NUM_CKPT rename-map checkpoints, so a branch mispredict restores only the map (selective recovery) instead of a full flush.

---
 rtl/reg_rename_ckpt.sv | 123 ++++++++++++
 tb/tb_reg_rename_ckpt.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_rename_ckpt.sv
// rtl/reg_rename_ckpt.sv - architectural register file with rename-status map and branch checkpoints
module reg_rename_ckpt #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int REG_W    = 5,
    parameter int ROB_W    = 4,
    parameter int NUM_RD   = 2,
    parameter int NUM_CKPT = 4,
    parameter int CK_W     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      flush,
    input  logic                      issue,
    input  logic [REG_W-1:0]          issue_rd,
    input  logic [ROB_W-1:0]          issue_rob_pos,
    input  logic [NUM_RD*REG_W-1:0]   rd_rs,
    output logic [NUM_RD*XLEN-1:0]    rd_val,
    output logic [NUM_RD-1:0]         rd_busy,
    output logic [NUM_RD*ROB_W-1:0]   rd_tag,
    input  logic                      commit,
    input  logic [REG_W-1:0]          commit_rd,
    input  logic [XLEN-1:0]           commit_val,
    input  logic [ROB_W-1:0]          commit_rob_pos,
    input  logic                      ck_save,
    input  logic [CK_W-1:0]           ck_save_id,
    input  logic                      ck_restore,
    input  logic [CK_W-1:0]           ck_restore_id
);

    // Live state: values, busy bits and producing ROB tags
    logic [NREG-1:0][XLEN-1:0]                 val_q, val_d;
    logic [NREG-1:0]                           busy_q, busy_d;
    logic [NREG-1:0][ROB_W-1:0]                tag_q, tag_d;
    // Checkpointed copies of the busy/tag map
    logic [NUM_CKPT-1:0][NREG-1:0]             ck_busy_q, ck_busy_d;
    logic [NUM_CKPT-1:0][NREG-1:0][ROB_W-1:0]  ck_tag_q, ck_tag_d;

    logic                                      commit_wr;
    logic                                      live_hit;
    logic [NREG-1:0]                           busy_c;
    logic [NUM_CKPT-1:0][NREG-1:0]             ck_busy_c;

    assign commit_wr = commit && (commit_rd != '0);
    // Commit retires the live rename only if it is still the youngest producer
    assign live_hit  = commit_wr && busy_q[commit_rd] && (tag_q[commit_rd] == commit_rob_pos);

    // Operand reads with same-cycle commit bypass; x0 always reads as idle zero
    always_comb begin
        rd_val  = '0;
        rd_busy = '0;
        rd_tag  = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            logic [REG_W-1:0] rs;
            rs = rd_rs[k*REG_W +: REG_W];
            if (rs != '0) begin
                rd_tag[k*ROB_W +: ROB_W] = tag_q[rs];
                if (live_hit && (rs == commit_rd)) begin
                    rd_val[k*XLEN +: XLEN] = commit_val;
                    rd_busy[k]             = 1'b0;
                end else begin
                    rd_val[k*XLEN +: XLEN] = val_q[rs];
                    rd_busy[k]             = busy_q[rs];
                end
            end
        end
    end

    // Next-state: commit clears first, then flush / restore / (save, issue) by priority
    always_comb begin
        busy_c = busy_q;
        if (live_hit) busy_c[commit_rd] = 1'b0;
        ck_busy_c = ck_busy_q;
        for (int c = 0; c < NUM_CKPT; c++) begin
            if (commit_wr && ck_busy_q[c][commit_rd] && (ck_tag_q[c][commit_rd] == commit_rob_pos))
                ck_busy_c[c][commit_rd] = 1'b0;
        end

        val_d    = val_q;
        busy_d   = busy_c;
        tag_d    = tag_q;
        ck_busy_d = ck_busy_c;
        ck_tag_d  = ck_tag_q;

        if (commit_wr) val_d[commit_rd] = commit_val;

        if (flush) begin
            busy_d    = '0;
            ck_busy_d = '0;
        end else if (ck_restore) begin
            busy_d = ck_busy_c[ck_restore_id];
            tag_d  = ck_tag_q[ck_restore_id];
        end else begin
            if (ck_save) begin
                ck_busy_d[ck_save_id] = busy_c;
                ck_tag_d[ck_save_id]  = tag_q;
            end
            if (issue && (issue_rd != '0)) begin
                busy_d[issue_rd] = 1'b1;
                tag_d[issue_rd]  = issue_rob_pos;
            end
        end
    end

    // State registers; rdy low freezes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q     <= '0;
            busy_q    <= '0;
            tag_q     <= '0;
            ck_busy_q <= '0;
            ck_tag_q  <= '0;
        end else if (rdy) begin
            val_q     <= val_d;
            busy_q    <= busy_d;
            tag_q     <= tag_d;
            ck_busy_q <= ck_busy_d;
            ck_tag_q  <= ck_tag_d;
        end
    end

endmodule

// File: tb/tb_reg_rename_ckpt.sv
// tb/tb_reg_rename_ckpt.sv - self-checking bench for reg_rename_ckpt
module tb_reg_rename_ckpt;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, issue, commit, ck_save, ck_restore;
    logic [4:0]  issue_rd, commit_rd;
    logic [3:0]  issue_rob_pos, commit_rob_pos;
    logic [31:0] commit_val;
    logic [1:0]  ck_save_id, ck_restore_id;
    logic [9:0]  rd_rs;
    logic [63:0] rd_val;
    logic [1:0]  rd_busy;
    logic [7:0]  rd_tag;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    // Reference model state
    logic [31:0] mval [32];
    bit          mbusy [32];
    logic [3:0]  mtag [32];
    bit          cbusy [4][32];
    logic [3:0]  ctag [4][32];

    always #5 clk = ~clk;

    reg_rename_ckpt dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .issue(issue), .issue_rd(issue_rd), .issue_rob_pos(issue_rob_pos),
        .rd_rs(rd_rs), .rd_val(rd_val), .rd_busy(rd_busy), .rd_tag(rd_tag),
        .commit(commit), .commit_rd(commit_rd), .commit_val(commit_val),
        .commit_rob_pos(commit_rob_pos),
        .ck_save(ck_save), .ck_save_id(ck_save_id),
        .ck_restore(ck_restore), .ck_restore_id(ck_restore_id)
    );

    task automatic model_step();
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                mval[r] = '0; mbusy[r] = 0; mtag[r] = '0;
                for (int c = 0; c < 4; c++) begin cbusy[c][r] = 0; ctag[c][r] = '0; end
            end
        end else if (rdy) begin
            if (commit && commit_rd != 0) begin
                mval[commit_rd] = commit_val;
                if (mbusy[commit_rd] && mtag[commit_rd] == commit_rob_pos) mbusy[commit_rd] = 0;
                for (int c = 0; c < 4; c++)
                    if (cbusy[c][commit_rd] && ctag[c][commit_rd] == commit_rob_pos) cbusy[c][commit_rd] = 0;
            end
            if (flush) begin
                for (int r = 0; r < 32; r++) begin
                    mbusy[r] = 0;
                    for (int c = 0; c < 4; c++) cbusy[c][r] = 0;
                end
            end else if (ck_restore) begin
                for (int r = 0; r < 32; r++) begin
                    mbusy[r] = cbusy[ck_restore_id][r];
                    mtag[r]  = ctag[ck_restore_id][r];
                end
            end else begin
                if (ck_save)
                    for (int r = 0; r < 32; r++) begin
                        cbusy[ck_save_id][r] = mbusy[r];
                        ctag[ck_save_id][r]  = mtag[r];
                    end
                if (issue && issue_rd != 0) begin
                    mbusy[issue_rd] = 1;
                    mtag[issue_rd]  = issue_rob_pos;
                end
            end
        end
    endtask

    task automatic exp_read(input logic [4:0] rs, output logic [31:0] v, output logic b, output logic [3:0] t);
        v = '0; b = 0; t = '0;
        if (rs != 0) begin
            t = mtag[rs];
            if (commit && commit_rd == rs && mbusy[rs] && mtag[rs] == commit_rob_pos) v = commit_val;
            else begin v = mval[rs]; b = mbusy[rs]; end
        end
    endtask

    task automatic idle();
        rst = 0; rdy = 1; flush = 0; issue = 0; commit = 0; ck_save = 0; ck_restore = 0;
        issue_rd = 0; commit_rd = 0; issue_rob_pos = 0; commit_rob_pos = 0; commit_val = 0;
        ck_save_id = 0; ck_restore_id = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset();
        idle(); rst = 1; rd_rs = 0;
        tick(); rst = 1; tick();
        rd_rs = {5'd5, 5'd5}; #1;
        tot_cnt++; if (rd_val !== 64'd0) $display("FAIL reset_val got %h exp 0", rd_val); else pass_cnt++;
        tot_cnt++; if (rd_busy !== 2'b00) $display("FAIL reset_busy got %b exp 00", rd_busy); else pass_cnt++;
        tot_cnt++; if (rd_tag !== 8'd0) $display("FAIL reset_tag got %h exp 0", rd_tag); else pass_cnt++;
    endtask

    task automatic test_commit_bypass();
        issue = 1; issue_rd = 3; issue_rob_pos = 7; tick();
        commit = 1; commit_rd = 3; commit_rob_pos = 7; commit_val = 32'hDEAD; rd_rs = {5'd0, 5'd3}; #1;
        tot_cnt++; if (rd_val[31:0] !== 32'hDEAD) $display("FAIL bypass_val got %h exp dead", rd_val[31:0]); else pass_cnt++;
        tot_cnt++; if (rd_busy[0] !== 1'b0) $display("FAIL bypass_busy got %b exp 0", rd_busy[0]); else pass_cnt++;
        tick(); rd_rs = {5'd0, 5'd3}; #1;
        tot_cnt++; if (rd_val[31:0] !== 32'hDEAD) $display("FAIL stored_val got %h exp dead", rd_val[31:0]); else pass_cnt++;
        tot_cnt++; if (rd_busy[0] !== 1'b0) $display("FAIL stored_busy got %b exp 0", rd_busy[0]); else pass_cnt++;
    endtask

    task automatic test_older_commit();
        issue = 1; issue_rd = 4; issue_rob_pos = 1; tick();
        issue = 1; issue_rd = 4; issue_rob_pos = 2; tick();
        commit = 1; commit_rd = 4; commit_rob_pos = 1; commit_val = 32'h11; rd_rs = {5'd0, 5'd4}; #1;
        tot_cnt++; if (rd_busy[0] !== 1'b1) $display("FAIL older_nobypass_busy got %b exp 1", rd_busy[0]); else pass_cnt++;
        tot_cnt++; if (rd_val[31:0] === 32'h11) $display("FAIL older_nobypass_val got %h exp not 11", rd_val[31:0]); else pass_cnt++;
        tick(); rd_rs = {5'd0, 5'd4}; #1;
        tot_cnt++; if (rd_val[31:0] !== 32'h11) $display("FAIL older_val got %h exp 11", rd_val[31:0]); else pass_cnt++;
        tot_cnt++; if (rd_busy[0] !== 1'b1) $display("FAIL older_busy got %b exp 1", rd_busy[0]); else pass_cnt++;
        tot_cnt++; if (rd_tag[3:0] !== 4'd2) $display("FAIL older_tag got %0d exp 2", rd_tag[3:0]); else pass_cnt++;
    endtask

    task automatic test_ckpt_restore();
        issue = 1; issue_rd = 6; issue_rob_pos = 3; tick();
        ck_save = 1; ck_save_id = 1; tick();
        issue = 1; issue_rd = 6; issue_rob_pos = 5; tick();
        issue = 1; issue_rd = 8; issue_rob_pos = 6; tick();
        rd_rs = {5'd8, 5'd6}; #1;
        tot_cnt++; if (rd_busy !== 2'b11) $display("FAIL ckpt_pre_busy got %b exp 11", rd_busy); else pass_cnt++;
        commit = 1; commit_rd = 6; commit_rob_pos = 3; commit_val = 32'h66;
        ck_restore = 1; ck_restore_id = 1; tick();
        rd_rs = {5'd8, 5'd6}; #1;
        tot_cnt++; if (rd_busy !== 2'b00) $display("FAIL ckpt_restore_busy got %b exp 00", rd_busy); else pass_cnt++;
        tot_cnt++; if (rd_val[31:0] !== 32'h66) $display("FAIL ckpt_restore_val got %h exp 66", rd_val[31:0]); else pass_cnt++;
    endtask

    task automatic test_flush();
        issue = 1; issue_rd = 11; issue_rob_pos = 4; tick();
        ck_save = 1; ck_save_id = 2; tick();
        flush = 1; ck_restore = 1; ck_restore_id = 2; issue = 1; issue_rd = 9; issue_rob_pos = 9;
        ck_save = 1; ck_save_id = 3; commit = 1; commit_rd = 10; commit_val = 32'hCAFE; commit_rob_pos = 0; tick();
        rd_rs = {5'd11, 5'd9}; #1;
        tot_cnt++; if (rd_busy !== 2'b00) $display("FAIL flush_busy got %b exp 00", rd_busy); else pass_cnt++;
        rd_rs = {5'd10, 5'd10}; #1;
        tot_cnt++; if (rd_val[63:32] !== 32'hCAFE) $display("FAIL flush_commit_val got %h exp cafe", rd_val[63:32]); else pass_cnt++;
        ck_restore = 1; ck_restore_id = 2; tick();
        rd_rs = {5'd11, 5'd11}; #1;
        tot_cnt++; if (rd_busy !== 2'b00) $display("FAIL flush_ckpt_busy got %b exp 00", rd_busy); else pass_cnt++;
    endtask

    task automatic test_x0();
        issue = 1; issue_rd = 0; issue_rob_pos = 2; commit = 1; commit_rd = 0; commit_val = 32'hFF;
        rd_rs = {5'd0, 5'd0}; #1;
        tot_cnt++; if (rd_val !== 64'd0) $display("FAIL x0_same_val got %h exp 0", rd_val); else pass_cnt++;
        tick(); rd_rs = {5'd0, 5'd0}; #1;
        tot_cnt++; if (rd_val !== 64'd0) $display("FAIL x0_val got %h exp 0", rd_val); else pass_cnt++;
        tot_cnt++; if (rd_busy !== 2'b00) $display("FAIL x0_busy got %b exp 00", rd_busy); else pass_cnt++;
    endtask

    task automatic test_rdy_hold();
        rdy = 0; issue = 1; issue_rd = 12; issue_rob_pos = 3; commit = 1; commit_rd = 13; commit_val = 32'h55; tick();
        rd_rs = {5'd13, 5'd12}; #1;
        tot_cnt++; if (rd_busy[0] !== 1'b0) $display("FAIL rdy_hold_busy got %b exp 0", rd_busy[0]); else pass_cnt++;
        tot_cnt++; if (rd_val[63:32] !== 32'd0) $display("FAIL rdy_hold_val got %h exp 0", rd_val[63:32]); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] ev; logic eb; logic [3:0] et; logic [4:0] rs;
        for (int n = 0; n < 600; n++) begin
            rdy        = ($urandom_range(0, 9) != 0);
            flush      = ($urandom_range(0, 39) == 0);
            ck_restore = ($urandom_range(0, 11) == 0);
            ck_save    = ($urandom_range(0, 5) == 0);
            ck_save_id = 2'($urandom_range(0, 3));
            ck_restore_id = 2'($urandom_range(0, 3));
            issue      = ($urandom_range(0, 2) != 0);
            issue_rd   = 5'($urandom_range(0, 15));
            issue_rob_pos = 4'($urandom_range(0, 15));
            commit     = ($urandom_range(0, 1) != 0);
            commit_rd  = 5'($urandom_range(0, 15));
            commit_val = $urandom;
            commit_rob_pos = ($urandom_range(0, 9) < 7) ? mtag[commit_rd] : 4'($urandom_range(0, 15));
            rd_rs = {5'($urandom_range(0, 15)), ($urandom_range(0, 1) != 0) ? commit_rd : 5'($urandom_range(0, 15))};
            #1;
            for (int k = 0; k < 2; k++) begin
                rs = rd_rs[k*5 +: 5];
                exp_read(rs, ev, eb, et);
                tot_cnt++; if (rd_val[k*32 +: 32] !== ev) $display("FAIL rand_val port%0d rs%0d got %h exp %h", k, rs, rd_val[k*32 +: 32], ev); else pass_cnt++;
                tot_cnt++; if (rd_busy[k] !== eb) $display("FAIL rand_busy port%0d rs%0d got %b exp %b", k, rs, rd_busy[k], eb); else pass_cnt++;
                if (eb) begin
                    tot_cnt++; if (rd_tag[k*4 +: 4] !== et) $display("FAIL rand_tag port%0d rs%0d got %0d exp %0d", k, rs, rd_tag[k*4 +: 4], et); else pass_cnt++;
                end
            end
            tick();
        end
    endtask

    initial begin
        idle(); rd_rs = 0;
        @(negedge clk);
        test_reset();
        test_commit_bypass();
        test_older_commit();
        test_ckpt_restore();
        test_flush();
        test_x0();
        test_rdy_hold();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
